// File: rtl/cdce62002_spi_config_pkg.sv
// Shared types and constants for the CDCE62002 SPI programming/verify block.
package cdce62002_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_LO,
        SHIFT_HI,
        GAP,
        VERIFY
    } state_t;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_RUN,
        SEQ_VERIFY
    } seq_t;

    localparam logic [3:0]  CDCE_RD_CMD = 4'hE;
    localparam int unsigned FRAME_BITS  = 32;

    localparam logic [2:0] OP_WR0 = 3'd0;
    localparam logic [2:0] OP_WR1 = 3'd1;
    localparam logic [2:0] OP_RC0 = 3'd2;
    localparam logic [2:0] OP_RD0 = 3'd3;
    localparam logic [2:0] OP_RC1 = 3'd4;
    localparam logic [2:0] OP_RD1 = 3'd5;

    function automatic logic [31:0] rd_cmd_word(input logic [3:0] addr);
        return {24'h0, addr, CDCE_RD_CMD};
    endfunction

endpackage

// File: rtl/cdce62002_spi_config_if.sv
// Sequencer handshake plus the four CDCE62002 SPI pins.
interface cdce62002_spi_config_if;
    logic       start;
    logic       busy;
    logic       done;
    logic       error;
    logic [3:0] retry_count;
    logic       spi_clk;
    logic       spi_mosi;
    logic       spi_cs_INV;
    logic       spi_miso;

    modport master (
        input  start, spi_miso,
        output busy, done, error, retry_count, spi_clk, spi_mosi, spi_cs_INV
    );

    modport slave (
        output start, spi_miso,
        input  busy, done, error, retry_count, spi_clk, spi_mosi, spi_cs_INV
    );
endinterface

// File: rtl/cdce62002_spi_config_shifter.sv
// 32-bit LSB-first SPI frame engine: setup cycle, 32 clocked bits, then a cs-high gap.
module spi_frame_shifter
    import cdce62002_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned CS_GAP  = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        go_i,
    input  logic [31:0] tx_word_i,
    input  logic        miso_i,
    output logic        spi_clk_o,
    output logic        spi_mosi_o,
    output logic        spi_cs_n_o,
    output logic [31:0] rx_word_o,
    output logic        frame_done_o
);
    localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);
    localparam int unsigned GAP_W = $clog2(CS_GAP + 1);

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [4:0]         bit_q, bit_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [31:0]        tx_q, tx_d;
    logic [31:0]        rx_q, rx_d;
    logic               div_last, gap_last;

    assign div_last = (div_q == DIV_W'(CLK_DIV - 1));
    assign gap_last = (gap_q == GAP_W'(CS_GAP - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        bit_d        = bit_q;
        gap_d        = gap_q;
        tx_d         = tx_q;
        rx_d         = rx_q;
        frame_done_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (go_i) begin
                    state_d = SETUP;
                    tx_d    = tx_word_i;
                end
            end
            SETUP: begin
                state_d = SHIFT_LO;
                div_d   = '0;
                bit_d   = '0;
            end
            SHIFT_LO: begin
                // miso is captured on the edge that raises spi_clk
                if (div_last) begin
                    div_d   = '0;
                    rx_d    = {miso_i, rx_q[31:1]};
                    state_d = SHIFT_HI;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            SHIFT_HI: begin
                if (div_last) begin
                    div_d = '0;
                    if (bit_q == 5'(FRAME_BITS - 1)) begin
                        state_d = GAP;
                        gap_d   = '0;
                    end else begin
                        bit_d   = bit_q + 5'd1;
                        tx_d    = {1'b0, tx_q[31:1]};
                        state_d = SHIFT_LO;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            GAP: begin
                if (div_last) begin
                    div_d = '0;
                    if (gap_last) begin
                        frame_done_o = 1'b1;
                        if (go_i) begin
                            state_d = SETUP;
                            tx_d    = tx_word_i;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign spi_clk_o  = (state_q == SHIFT_HI);
    assign spi_cs_n_o = !(state_q inside {SETUP, SHIFT_LO, SHIFT_HI});
    assign spi_mosi_o = (state_q inside {SHIFT_LO, SHIFT_HI}) && tx_q[0];
    assign rx_word_o  = rx_q;

endmodule

// File: rtl/cdce62002_spi_config.sv
// CDCE62002 programmer: writes REG0/REG1, reads both back, compares, retries on mismatch.
module cdce62002_spi_config
    import cdce62002_pkg::*;
#(
    parameter logic [27:0]  REG0_VALUE  = 28'h0000000,
    parameter logic [27:0]  REG1_VALUE  = 28'h0000000,
    parameter int unsigned  CLK_DIV     = 2,
    parameter int unsigned  CS_GAP      = 4,
    parameter int unsigned  MAX_RETRIES = 3
) (
    input  logic                    sysclk,
    input  logic                    reset_INV,
    cdce62002_spi_config_if.master  cfg
);
    localparam logic [3:0]  MAX_R    = 4'(MAX_RETRIES);
    localparam logic [31:0] CMP_MASK = 32'hFFFF_FFF0;

    seq_t        seq_q, seq_d;
    logic [2:0]  op_q, op_d;
    logic [3:0]  retry_q, retry_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] rd0_q, rd0_d;
    logic [31:0] rd1_q, rd1_d;
    logic        go, frame_done, verify_ok;
    logic [31:0] tx_word, rx_word;

    function automatic logic [31:0] op_word(input logic [2:0] op);
        case (op)
            OP_WR0:  return {REG0_VALUE, 4'h0};
            OP_WR1:  return {REG1_VALUE, 4'h1};
            OP_RC0:  return rd_cmd_word(4'h0);
            OP_RC1:  return rd_cmd_word(4'h1);
            default: return '0;
        endcase
    endfunction

    // The readback address nibble is don't-care, so it is masked out of the compare.
    assign verify_ok = (((rd0_q ^ {REG0_VALUE, 4'h0}) & CMP_MASK) == '0) &&
                       (((rd1_q ^ {REG1_VALUE, 4'h0}) & CMP_MASK) == '0);

    // tx_word follows the next op so the shifter can reload straight out of GAP.
    assign tx_word = op_word(op_d);

    always_ff @(posedge sysclk or negedge reset_INV) begin
        if (!reset_INV) begin
            seq_q   <= SEQ_IDLE;
            op_q    <= OP_WR0;
            retry_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rd0_q   <= '0;
            rd1_q   <= '0;
        end else begin
            seq_q   <= seq_d;
            op_q    <= op_d;
            retry_q <= retry_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
        end
    end

    always_comb begin
        seq_d   = seq_q;
        op_d    = op_q;
        retry_d = retry_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        rd0_d   = rd0_q;
        rd1_d   = rd1_q;
        go      = 1'b0;
        unique case (seq_q)
            SEQ_IDLE: begin
                if (cfg.start) begin
                    seq_d   = SEQ_RUN;
                    op_d    = OP_WR0;
                    retry_d = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    go      = 1'b1;
                end
            end
            SEQ_RUN: begin
                if (frame_done) begin
                    if (op_q == OP_RD0) rd0_d = rx_word;
                    if (op_q == OP_RD1) begin
                        rd1_d = rx_word;
                        seq_d = SEQ_VERIFY;
                    end else begin
                        op_d = op_q + 3'd1;
                        go   = 1'b1;
                    end
                end
            end
            SEQ_VERIFY: begin
                if (verify_ok) begin
                    seq_d  = SEQ_IDLE;
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end else if (retry_q < MAX_R) begin
                    seq_d   = SEQ_RUN;
                    retry_d = retry_q + 4'd1;
                    op_d    = OP_WR0;
                    go      = 1'b1;
                end else begin
                    seq_d  = SEQ_IDLE;
                    busy_d = 1'b0;
                    err_d  = 1'b1;
                end
            end
            default: seq_d = SEQ_IDLE;
        endcase
    end

    spi_frame_shifter #(
        .CLK_DIV (CLK_DIV),
        .CS_GAP  (CS_GAP)
    ) u_shifter (
        .clk_i        (sysclk),
        .rst_ni       (reset_INV),
        .go_i         (go),
        .tx_word_i    (tx_word),
        .miso_i       (cfg.spi_miso),
        .spi_clk_o    (cfg.spi_clk),
        .spi_mosi_o   (cfg.spi_mosi),
        .spi_cs_n_o   (cfg.spi_cs_INV),
        .rx_word_o    (rx_word),
        .frame_done_o (frame_done)
    );

    assign cfg.busy        = busy_q;
    assign cfg.done        = done_q;
    assign cfg.error       = err_q;
    assign cfg.retry_count = retry_q;

endmodule
